reg_port_ctrl: RTL and testbench

- Sequences all traffic into the reg_data register file: one shared write port, one dual-address read port.
- Round-robin arbitration of two writeback requesters (0 = ALU, 1 = load unit) onto the single write port.
- Accepts read requests, accounts for the file's 1-cycle registered read, and delivers results through a valid/ready response with a skid buffer.
- Detects read-after-write collisions and stalls the read instead of returning stale data.

---
 rtl/reg_port_ctrl_pkg.sv | 26 ++
 rtl/reg_port_ctrl_rr_arb2.sv | 47 ++++
 rtl/reg_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_reg_port_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_port_ctrl_pkg
//  Description : Shared constants for the reg_data port controller: default
//                data/address widths, response FSM encoding and requester
//                indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_port_ctrl_pkg;

    // Keep BIT_DATA in step with the reg_data register file data width.
    localparam int BIT_DATA    = 8;
    localparam int SZB_DEFAULT = 4;

    // Response FSM encoding.
    localparam int              ST_W    = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd2;

    // Writeback requester indices.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage : reg_port_ctrl_pkg
`default_nettype wire

// File: rtl/reg_port_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter. The last granted index is
//                held in r_last; on contention the other requester wins.
//                Grants are forced low while reset is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import reg_port_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last;
    logic w_gnt0;
    logic w_gnt1;

    // Grant a lone requester; on contention grant the one not served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            w_gnt0 = i_req0 && (!i_req1 || (r_last == REQ_LOAD));
            w_gnt1 = i_req1 && (!i_req0 || (r_last == REQ_ALU));
        end
    end

    // Remember the last winner; idle cycles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= REQ_LOAD;
        end else if (w_gnt0 || w_gnt1) begin
            r_last <= w_gnt1 ? REQ_LOAD : REQ_ALU;
        end
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/reg_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_port_ctrl
//  Description : Port sequencer for the reg_data register file. Arbitrates
//                two writeback requesters onto the single write port, stalls
//                reads that collide with the in-flight write, and returns the
//                1-cycle registered read data through a valid/ready response
//                backed by a one-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_port_ctrl
    import reg_port_ctrl_pkg::*;
#(
    parameter int BIT = BIT_DATA,
    parameter int SZB = SZB_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           wr0_valid,
    input  logic [SZB-1:0] wr0_addr,
    input  logic [BIT-1:0] wr0_data,
    output logic           wr0_ready,
    input  logic           wr1_valid,
    input  logic [SZB-1:0] wr1_addr,
    input  logic [BIT-1:0] wr1_data,
    output logic           wr1_ready,
    input  logic           rd_valid,
    input  logic [SZB-1:0] rd_addr0,
    input  logic [SZB-1:0] rd_addr1,
    output logic           rd_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [BIT-1:0] resp_data0,
    output logic [BIT-1:0] resp_data1,
    output logic           rf_we,
    output logic [SZB-1:0] rf_addr_rd,
    output logic [BIT-1:0] rf_rd,
    output logic [SZB-1:0] rf_addr_rs0,
    output logic [SZB-1:0] rf_addr_rs1,
    input  logic [BIT-1:0] rf_rs0,
    input  logic [BIT-1:0] rf_rs1
);

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_hz;
    logic            w_rd_ready;
    logic            w_skid_load;
    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic [BIT-1:0]  r_skid0;
    logic [BIT-1:0]  r_skid1;

    rr_arb2 u_arb (
        .clk    (clock),
        .rst    (reset),
        .i_req0 (wr0_valid),
        .i_req1 (wr1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // Steer the granted requester onto the write port; idle port reads zero.
    always_comb begin
        rf_we      = w_gnt0 || w_gnt1;
        rf_addr_rd = '0;
        rf_rd      = '0;
        if (w_gnt1) begin
            rf_addr_rd = wr1_addr;
            rf_rd      = wr1_data;
        end else if (w_gnt0) begin
            rf_addr_rd = wr0_addr;
            rf_rd      = wr0_data;
        end
    end

    assign wr0_ready = w_gnt0;
    assign wr1_ready = w_gnt1;

    // A read touching the register being written this cycle would see the
    // old value, so it is held off until the write has landed.
    assign w_hz = rf_we && ((rf_addr_rd == rd_addr0) || (rf_addr_rd == rd_addr1));

    // Response FSM: next state, read acceptance and response outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_ready  = 1'b0;
        w_skid_load = 1'b0;
        resp_valid  = 1'b0;
        resp_data0  = '0;
        resp_data1  = '0;
        case (r_state)
            ST_IDLE: begin
                w_rd_ready = !w_hz;
                if (rd_valid && !w_hz) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                resp_valid = 1'b1;
                resp_data0 = rf_rs0;
                resp_data1 = rf_rs1;
                if (resp_ready) begin
                    w_rd_ready  = !w_hz;
                    w_state_nxt = (rd_valid && !w_hz) ? ST_BUSY : ST_IDLE;
                end else begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                resp_valid = 1'b1;
                resp_data0 = r_skid0;
                resp_data1 = r_skid1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Everything reads zero while reset is held, not just after the edge.
        if (reset) begin
            w_rd_ready  = 1'b0;
            w_skid_load = 1'b0;
            resp_valid  = 1'b0;
            resp_data0  = '0;
            resp_data1  = '0;
        end
    end

    assign rd_ready    = w_rd_ready;
    assign rf_addr_rs0 = w_rd_ready ? rd_addr0 : '0;
    assign rf_addr_rs1 = w_rd_ready ? rd_addr1 : '0;

    // Response FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Skid buffer: snapshot file outputs when a fresh response is refused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skid0 <= '0;
            r_skid1 <= '0;
        end else if (w_skid_load) begin
            r_skid0 <= rf_rs0;
            r_skid1 <= rf_rs1;
        end
    end

endmodule : reg_port_ctrl
`default_nettype wire

// File: tb/tb_reg_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_port_ctrl
//  Description : Self-checking bench for reg_port_ctrl with a behavioural
//                reg_data file model and a transaction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_port_ctrl;

    localparam int BIT = 8;
    localparam int SZB = 4;
    localparam int NREG = 1 << SZB;

    logic           clock = 1'b0;
    logic           reset;
    logic           wr0_valid, wr1_valid, rd_valid, resp_ready;
    logic [SZB-1:0] wr0_addr, wr1_addr, rd_addr0, rd_addr1;
    logic [BIT-1:0] wr0_data, wr1_data;
    logic           wr0_ready, wr1_ready, rd_ready, resp_valid, rf_we;
    logic [BIT-1:0] resp_data0, resp_data1, rf_rd, rf_rs0, rf_rs1;
    logic [SZB-1:0] rf_addr_rd, rf_addr_rs0, rf_addr_rs1;

    reg_port_ctrl #(.BIT(BIT), .SZB(SZB)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr0_valid  (wr0_valid),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .rd_valid   (rd_valid),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_ready   (rd_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data0 (resp_data0),
        .resp_data1 (resp_data1),
        .rf_we      (rf_we),
        .rf_addr_rd (rf_addr_rd),
        .rf_rd      (rf_rd),
        .rf_addr_rs0(rf_addr_rs0),
        .rf_addr_rs1(rf_addr_rs1),
        .rf_rs0     (rf_rs0),
        .rf_rs1     (rf_rs1)
    );

    always #5 clock = ~clock;

    // reg_data stand-in: synchronous write, 1-cycle registered dual read.
    logic [BIT-1:0] mem [NREG];
    always @(posedge clock) begin
        if (rf_we) mem[rf_addr_rd] <= rf_rd;
        rf_rs0 <= mem[rf_addr_rs0];
        rf_rs1 <= mem[rf_addr_rs1];
    end

    // Reference: register contents, last winner, one outstanding response.
    logic [BIT-1:0] shadow [NREG];
    logic           m_last;
    logic           m_pend;
    logic           m_held;
    logic [BIT-1:0] m_d0, m_d1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_pend = 1'b0;
        m_held = 1'b0;
        m_d0   = '0;
        m_d1   = '0;
    endtask

    // One clock cycle: drive, check the combinational view, advance model.
    task automatic do_cycle(
        input logic           rs,
        input logic           v0, input logic [SZB-1:0] a0, input logic [BIT-1:0] d0,
        input logic           v1, input logic [SZB-1:0] a1, input logic [BIT-1:0] d1,
        input logic           rv, input logic [SZB-1:0] ra0, input logic [SZB-1:0] ra1,
        input logic           rr
    );
        logic           eg0, eg1, ewe, ehz, erdy, evld, acc;
        logic [SZB-1:0] ewa;
        logic [BIT-1:0] ewd, ed0, ed1, nd0, nd1;
        @(negedge clock);
        reset = rs;
        wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
        wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
        rd_valid = rv; rd_addr0 = ra0; rd_addr1 = ra1; resp_ready = rr;
        #1;
        eg0 = 0; eg1 = 0; ewa = '0; ewd = '0; erdy = 0; evld = 0; ed0 = '0; ed1 = '0;
        if (!rs) begin
            eg0 = v0 && (!v1 || m_last);
            eg1 = v1 && (!v0 || !m_last);
            if (eg1) begin ewa = a1; ewd = d1; end
            else if (eg0) begin ewa = a0; ewd = d0; end
            ehz  = (eg0 || eg1) && (ewa == ra0 || ewa == ra1);
            erdy = !ehz && (!m_pend || (rr && !m_held));
            evld = m_pend;
            if (m_pend) begin ed0 = m_d0; ed1 = m_d1; end
        end
        ewe = eg0 || eg1;
        chk("wr0_ready",   32'(wr0_ready),   32'(eg0));
        chk("wr1_ready",   32'(wr1_ready),   32'(eg1));
        chk("rf_we",       32'(rf_we),       32'(ewe));
        chk("rf_addr_rd",  32'(rf_addr_rd),  32'(ewa));
        chk("rf_rd",       32'(rf_rd),       32'(ewd));
        chk("rd_ready",    32'(rd_ready),    32'(erdy));
        chk("rf_addr_rs0", 32'(rf_addr_rs0), 32'(erdy ? ra0 : 4'd0));
        chk("rf_addr_rs1", 32'(rf_addr_rs1), 32'(erdy ? ra1 : 4'd0));
        chk("resp_valid",  32'(resp_valid),  32'(evld));
        chk("resp_data0",  32'(resp_data0),  32'(ed0));
        chk("resp_data1",  32'(resp_data1),  32'(ed1));
        @(posedge clock);
        if (rs) begin
            model_reset();
        end else begin
            acc = rv && erdy;
            nd0 = shadow[ra0];
            nd1 = shadow[ra1];
            if (ewe) begin
                shadow[ewa] = ewd;
                m_last = eg1;
            end
            if (m_pend && rr) m_pend = 1'b0;
            else if (m_pend)  m_held = 1'b1;
            if (acc) begin
                m_pend = 1'b1; m_held = 1'b0; m_d0 = nd0; m_d1 = nd1;
            end
        end
    endtask

    task automatic check_reset_zero();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data0", 32'(resp_data0), 32'd0);
        chk("rst_rd_ready",   32'(rd_ready),   32'd0);
        chk("rst_rf_we",      32'(rf_we),      32'd0);
        chk("rst_wr0_ready",  32'(wr0_ready),  32'd0);
        chk("rst_wr1_ready",  32'(wr1_ready),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        model_reset();
        reset = 1'b1;
        wr0_valid = 0; wr1_valid = 0; rd_valid = 0; resp_ready = 0;
        wr0_addr = '0; wr1_addr = '0; rd_addr0 = '0; rd_addr1 = '0;
        wr0_data = '0; wr1_data = '0;

        // Reset with requests present: nothing may be granted or written.
        do_cycle(1, 1, 4'd9, 8'hEE, 1, 4'd9, 8'hDD, 1, 4'd1, 4'd2, 1);
        do_cycle(1, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 0);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 0);

        // Contention for 4 cycles: grants alternate starting with 0.
        for (int i = 0; i < 4; i++)
            do_cycle(0, 1, 4'd2, 8'(8'h20 + i), 1, 4'd3, 8'(8'h30 + i), 0, 4'd0, 4'd0, 1);

        // Preload reg n = n*0x11.
        for (int n = 0; n < NREG; n++)
            do_cycle(0, 1, 4'(n), 8'(n * 8'h11), 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);

        // Read-after-write collision on reg 7.
        do_cycle(0, 0, 4'd0, 8'h00, 1, 4'd7, 8'h5A, 1, 4'd7, 4'd1, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd7, 4'd1, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);
        chk("raw_shadow7", 32'(shadow[7]), 32'h5A);

        // Back-to-back reads with the consumer always ready.
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd1, 4'd2, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd3, 4'd4, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);

        // Held response with a write to the held register during the stall.
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd5, 4'd6, 0);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd8, 4'd9, 0);
        do_cycle(0, 1, 4'd5, 8'hFF, 0, 4'd0, 8'h00, 1, 4'd8, 4'd9, 0);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd8, 4'd9, 0);
        chk("hold_data0", 32'(resp_data0), 32'h55);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd8, 4'd9, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 1);

        // Reset while holding: response drops immediately.
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd1, 4'd2, 0);
        do_cycle(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd0, 4'd0, 0);
        chk("pre_reset_valid", 32'(resp_valid), 32'd1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_zero();
        do_cycle(1, 1, 4'd4, 8'hA4, 1, 4'd6, 8'hB6, 0, 4'd0, 4'd0, 0);
        model_reset();
        do_cycle(0, 1, 4'd10, 8'hA0, 1, 4'd11, 8'hB1, 0, 4'd0, 4'd0, 1);
        do_cycle(0, 1, 4'd10, 8'hA2, 1, 4'd11, 8'hB3, 0, 4'd0, 4'd0, 1);

        // Random traffic with narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            do_cycle(0,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_port_ctrl
`default_nettype wire
